// File: rtl/cache_miss_controller_pkg.sv
// Shared cache definitions: line geometry, miss-controller state encodings, word select.
package cache_pkg;

    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_BITS      = 128;
    localparam int WORD_BITS      = 32;

    typedef logic [1:0] beat_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WB     = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_REFILL = 3'd3;
    localparam logic [2:0] ST_FILL   = 3'd4;
    localparam logic [2:0] ST_RESUME = 3'd5;

    // Word 0 sits in the most significant 32 bits of the line.
    function automatic logic [WORD_BITS-1:0] word_sel(input logic [LINE_BITS-1:0] block,
                                                      input int n);
        return block[LINE_BITS-1-WORD_BITS*n -: WORD_BITS];
    endfunction

endpackage

// File: rtl/cache_miss_controller_if.sv
// Miss-controller bus bundle: lookup/victim inputs, memory handshake, refill and write-back outputs.
interface cache_miss_controller_if
    import cache_pkg::*;
#(
    parameter int ADDR_BITS = 12
);
    logic                   i_miss;
    logic [ADDR_BITS-5:0]   i_miss_line_addr;
    logic                   i_victim_dirty;
    logic [ADDR_BITS-5:0]   i_victim_line_addr;
    logic [LINE_BITS-1:0]   i_victim_block;
    logic                   i_ready_mm;
    logic                   i_refill_done;
    logic                   o_sample;
    logic                   o_refill_en;
    logic [ADDR_BITS-5:0]   o_base_addr;
    logic [ADDR_BITS-3:0]   o_wb_addr;
    logic [WORD_BITS-1:0]   o_wb_data;
    logic                   o_wb_we;
    logic                   o_line_we;
    logic                   o_stall;
    logic [2:0]             o_state_probe;

    modport slave (
        input  i_miss, i_miss_line_addr, i_victim_dirty, i_victim_line_addr, i_victim_block,
               i_ready_mm, i_refill_done,
        output o_sample, o_refill_en, o_base_addr, o_wb_addr, o_wb_data, o_wb_we,
               o_line_we, o_stall, o_state_probe
    );

    modport master (
        output i_miss, i_miss_line_addr, i_victim_dirty, i_victim_line_addr, i_victim_block,
               i_ready_mm, i_refill_done,
        input  o_sample, o_refill_en, o_base_addr, o_wb_addr, o_wb_data, o_wb_we,
               o_line_we, o_stall, o_state_probe
    );

endinterface

// File: rtl/cache_miss_controller_wb_word_mux.sv
// 128->32 word selector on beat index; word 0 is the most significant word of the line.
module wb_word_mux
    import cache_pkg::*;
(
    input  logic [LINE_BITS-1:0] block,
    input  beat_t                beat,
    output logic [WORD_BITS-1:0] word
);

    logic [WORD_BITS-1:0] words [WORDS_PER_LINE];

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
            assign words[gi] = word_sel(block, gi);
        end
    endgenerate

    assign word = words[beat];

endmodule

// File: rtl/cache_miss_controller.sv
// Data-cache miss FSM: optional dirty-victim write-back, refill handshake, line commit, core stall.
// CACHE_WRITEBACK_EN enables the write-back path; without it the cache is write-through.
module cache_miss_controller
    import cache_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input logic                    clk_inv,
    input logic                    nrst,
    cache_miss_controller_if.slave bus
);

    localparam int LINE_W = ADDR_BITS - 4;

    logic [2:0]           state_reg, state_next;
    beat_t                beat_reg, beat_next;
    logic [LINE_W-1:0]    miss_addr_reg;
    logic                 take_miss;
    logic                 go_wb;
    logic [WORD_BITS-1:0] wb_word;

    assign take_miss = (state_reg == ST_IDLE) && bus.i_miss;

`ifdef CACHE_WRITEBACK_EN
    logic [LINE_W-1:0]    victim_addr_reg;
    logic [LINE_BITS-1:0] block_reg;

    assign go_wb = bus.i_victim_dirty;

    always_ff @(posedge clk_inv) begin
        if (!nrst) begin
            victim_addr_reg <= '0;
            block_reg       <= '0;
        end else if (take_miss) begin
            victim_addr_reg <= bus.i_victim_line_addr;
            block_reg       <= bus.i_victim_block;
        end
    end

    wb_word_mux u_wb_word_mux (
        .block (block_reg),
        .beat  (beat_reg),
        .word  (wb_word)
    );

    assign bus.o_wb_we   = (state_reg == ST_WB) && bus.i_ready_mm;
    assign bus.o_wb_addr = (state_reg == ST_WB) ? {victim_addr_reg, beat_reg} : '0;
    assign bus.o_wb_data = (state_reg == ST_WB) ? wb_word : '0;
`else
    logic unused_victim;

    assign go_wb = 1'b0;

    // Selector kept elaborated so the shared sub-module stays in the hierarchy.
    wb_word_mux u_wb_word_mux (
        .block (bus.i_victim_block),
        .beat  (beat_reg),
        .word  (wb_word)
    );

    assign unused_victim = ^{bus.i_victim_dirty, bus.i_victim_line_addr, wb_word};

    assign bus.o_wb_we   = 1'b0;
    assign bus.o_wb_addr = '0;
    assign bus.o_wb_data = '0;
`endif

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.i_miss) begin
                    state_next = go_wb ? ST_WB : ST_SAMPLE;
                end
            end
`ifdef CACHE_WRITEBACK_EN
            ST_WB: begin
                if (bus.i_ready_mm) begin
                    beat_next = beat_reg + 2'd1;
                    if (beat_reg == 2'd3) begin
                        state_next = ST_SAMPLE;
                    end
                end
            end
`endif
            ST_SAMPLE: state_next = ST_REFILL;
            // Refill-done reads 1 before the first beat, so only the beat count ends REFILL.
            ST_REFILL: begin
                if (bus.i_ready_mm) begin
                    beat_next = beat_reg + 2'd1;
                    if (beat_reg == 2'd3) begin
                        state_next = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (bus.i_refill_done) begin
                    state_next = ST_RESUME;
                end
            end
            ST_RESUME: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_inv) begin
        if (!nrst) begin
            state_reg     <= ST_IDLE;
            beat_reg      <= '0;
            miss_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            if (take_miss) begin
                miss_addr_reg <= bus.i_miss_line_addr;
            end
        end
    end

    assign bus.o_sample      = (state_reg == ST_SAMPLE);
    assign bus.o_refill_en   = (state_reg == ST_REFILL);
    assign bus.o_line_we     = (state_reg == ST_FILL) && bus.i_refill_done;
    assign bus.o_base_addr   = miss_addr_reg;
    assign bus.o_state_probe = state_reg;
    assign bus.o_stall       = (state_reg == ST_IDLE) ? bus.i_miss
                             : (state_reg inside {ST_WB, ST_SAMPLE, ST_REFILL, ST_FILL});

endmodule

// File: tb/tb_cache_miss_controller.sv
// Self-checking bench for cache_miss_controller: phase-count reference model plus directed literals.
module tb_cache_miss_controller;
    import cache_pkg::*;

    localparam int AB = 12;
    localparam int LW = AB - 4;
`ifdef CACHE_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic clk_inv = 1'b0;
    logic nrst    = 1'b0;

    cache_miss_controller_if #(.ADDR_BITS(AB)) bus ();

    cache_miss_controller #(.ADDR_BITS(AB)) dut (
        .clk_inv (clk_inv),
        .nrst    (nrst),
        .bus     (bus.slave)
    );

    always #5 clk_inv = ~clk_inv;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining work per phase of the current miss.
    int            m_wb_left;
    int            m_ref_left;
    bit            m_sample, m_fill, m_resume;
    logic [LW-1:0] m_base, m_victim;
    logic [127:0]  m_block;

    initial begin
        logic [2:0]    e_probe;
        logic          e_stall, e_sample, e_ren, e_wbwe, e_lwe;
        logic [AB-3:0] e_wbaddr;
        logic [31:0]   e_wbdata;
        logic [127:0]  sh;
        int            n;
        forever begin
            @(negedge clk_inv);
            if (!nrst) begin
                m_wb_left = 0; m_ref_left = 0; m_sample = 0; m_fill = 0; m_resume = 0;
                m_base = '0; m_victim = '0; m_block = '0;
            end else begin
                e_probe = 3'd0; e_stall = 0; e_sample = 0; e_ren = 0; e_wbwe = 0; e_lwe = 0;
                e_wbaddr = '0; e_wbdata = '0;
                if (m_wb_left > 0) begin
                    n        = 4 - m_wb_left;
                    e_probe  = 3'd1;
                    e_stall  = 1;
                    e_wbwe   = bus.i_ready_mm;
                    e_wbaddr = {m_victim, 2'(n)};
                    sh       = m_block >> (32 * (3 - n));
                    e_wbdata = sh[31:0];
                end else if (m_sample) begin
                    e_probe = 3'd2; e_stall = 1; e_sample = 1;
                end else if (m_ref_left > 0) begin
                    e_probe = 3'd3; e_stall = 1; e_ren = 1;
                end else if (m_fill) begin
                    e_probe = 3'd4; e_stall = 1; e_lwe = bus.i_refill_done;
                end else if (m_resume) begin
                    e_probe = 3'd5;
                end else begin
                    e_stall = bus.i_miss;
                end
                check("state_probe", bus.o_state_probe, e_probe);
                check("stall",       bus.o_stall,       e_stall);
                check("sample",      bus.o_sample,      e_sample);
                check("refill_en",   bus.o_refill_en,   e_ren);
                check("base_addr",   bus.o_base_addr,   m_base);
                check("wb_we",       bus.o_wb_we,       e_wbwe);
                check("wb_addr",     bus.o_wb_addr,     e_wbaddr);
                check("wb_data",     bus.o_wb_data,     e_wbdata);
                check("line_we",     bus.o_line_we,     e_lwe);
                // advance the model by one clock
                if (m_wb_left > 0) begin
                    if (bus.i_ready_mm) m_wb_left--;
                end else if (m_sample) begin
                    m_sample = 0;
                end else if (m_ref_left > 0) begin
                    if (bus.i_ready_mm) m_ref_left--;
                end else if (m_fill) begin
                    if (bus.i_refill_done) begin
                        m_fill = 0; m_resume = 1;
                    end
                end else if (m_resume) begin
                    m_resume = 0;
                end else if (bus.i_miss) begin
                    m_base     = bus.i_miss_line_addr;
                    m_victim   = bus.i_victim_line_addr;
                    m_block    = bus.i_victim_block;
                    m_wb_left  = (WB_EN && bus.i_victim_dirty) ? 4 : 0;
                    m_sample   = 1;
                    m_ref_left = 4;
                    m_fill     = 1;
                end
            end
        end
    end

    // Per-transaction observations
    logic [AB-3:0] wb_addr_q[$];
    logic [31:0]   wb_data_q[$];
    int            n_ref, n_lwe, n_smp;
    logic [LW-1:0] smp_base;
    int            txn = 0;

    // rmode: 0 ready high, 1 ready on every third cycle, 2 random. hold: FILL cycles with done low.
    task automatic run_miss(input logic [LW-1:0] line, input logic dirty, input logic [LW-1:0] victim,
                            input logic [127:0] blk, input int rmode, input int hold,
                            input bit noisy, output int lat);
        int k, fill_cnt;
        bit fin;
        wb_addr_q.delete(); wb_data_q.delete();
        n_ref = 0; n_lwe = 0; n_smp = 0; smp_base = '0;
        bus.i_miss = 1; bus.i_miss_line_addr = line; bus.i_victim_dirty = dirty;
        bus.i_victim_line_addr = victim; bus.i_victim_block = blk;
        bus.i_ready_mm = 1; bus.i_refill_done = 1;
        k = 0; fill_cnt = 0; fin = 0; lat = -1;
        while (!fin && k < 400) begin
            @(negedge clk_inv);
            if (bus.o_wb_we) begin
                wb_addr_q.push_back(bus.o_wb_addr);
                wb_data_q.push_back(bus.o_wb_data);
            end
            if (bus.o_refill_en && bus.i_ready_mm) n_ref++;
            if (bus.o_line_we) n_lwe++;
            if (bus.o_sample) begin
                n_smp++;
                smp_base = bus.o_base_addr;
            end
            if (k > 0 && !bus.o_stall) begin
                fin = 1;
                lat = k;
            end
            @(posedge clk_inv);
            #1;
            k++;
            bus.i_miss = (noisy && !fin) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noisy) begin
                bus.i_miss_line_addr   = LW'($urandom);
                bus.i_victim_line_addr = LW'($urandom);
                bus.i_victim_dirty     = 1'($urandom_range(0, 1));
                bus.i_victim_block     = {$urandom, $urandom, $urandom, $urandom};
            end
            case (rmode)
                0:       bus.i_ready_mm = 1'b1;
                1:       bus.i_ready_mm = (k % 3 == 0);
                default: bus.i_ready_mm = ($urandom_range(0, 9) < 7);
            endcase
            if (bus.o_state_probe == 3'd4) begin
                bus.i_refill_done = (fill_cnt >= hold);
                fill_cnt++;
            end else begin
                bus.i_refill_done = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        if (!fin) begin
            n_cmp++;
            n_err++;
            $display("FAIL txn_timeout: got no resume expected resume within 400 cycles");
        end
        txn++;
        $display("txn %0d: line=%h dirty=%0d victim=%h rmode=%0d hold=%0d latency=%0d wb_beats=%0d refill_beats=%0d",
                 txn, line, dirty, victim, rmode, hold, lat, wb_addr_q.size(), n_ref);
    endtask

    initial begin
        int lat, cnt;
        logic [127:0] blk;
        bus.i_miss = 0; bus.i_miss_line_addr = '0; bus.i_victim_dirty = 0;
        bus.i_victim_line_addr = '0; bus.i_victim_block = '0;
        bus.i_ready_mm = 0; bus.i_refill_done = 0;
        repeat (3) @(posedge clk_inv);
        #1 nrst = 1;
        @(negedge clk_inv);
        check("rst_probe",   bus.o_state_probe, 3'd0);
        check("rst_stall",   bus.o_stall,       1'b0);
        check("rst_base",    bus.o_base_addr,   8'h00);
        check("rst_wb_addr", bus.o_wb_addr,     10'h000);
        check("rst_refill",  bus.o_refill_en,   1'b0);
        @(posedge clk_inv); #1;

        // Clean miss, line 0x2A
        run_miss(8'h2A, 1'b0, 8'h33, {4{32'h5555_AAAA}}, 0, 0, 0, lat);
        check("clean_sample_cnt", n_smp, 1);
        check("clean_base",       smp_base, 8'h2A);
        check("clean_beats",      n_ref, 4);
        check("clean_line_we",    n_lwe, 1);
        check("clean_latency",    lat, 7);
        check("clean_no_wb",      wb_addr_q.size(), 0);

        // Dirty miss, victim 0x11, block {A,B,C,D}
        blk = {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        run_miss(8'h3C, 1'b1, 8'h11, blk, 0, 0, 0, lat);
        check("dirty_latency", lat, WB_EN ? 11 : 7);
        check("dirty_wb_cnt",  wb_addr_q.size(), WB_EN ? 4 : 0);
        if (wb_addr_q.size() == 4) begin
            check("dirty_wb_addr0", wb_addr_q[0], 10'h044);
            check("dirty_wb_addr3", wb_addr_q[3], 10'h047);
            check("dirty_wb_data0", wb_data_q[0], 32'hAAAA_0001);
            check("dirty_wb_data2", wb_data_q[2], 32'hCCCC_0003);
        end
        check("dirty_beats", n_ref, 4);

        // Ready toggling 1,0,0,1,... through WB and REFILL
        run_miss(8'h77, 1'b1, 8'h11, blk, 1, 0, 0, lat);
        check("toggle_latency", lat, WB_EN ? 26 : 14);
        check("toggle_wb_cnt",  wb_addr_q.size(), WB_EN ? 4 : 0);
        for (int i = 0; i < wb_addr_q.size(); i++) begin
            logic [AB-3:0] ea;
            ea = {8'h11, 2'(i)};
            check("toggle_wb_seq", wb_addr_q[i], ea);
        end
        check("toggle_beats", n_ref, 4);

        // Refill-done held low for three FILL cycles
        run_miss(8'h05, 1'b0, 8'h00, '0, 0, 3, 0, lat);
        check("hold_latency", lat, 10);
        check("hold_line_we", n_lwe, 1);

        // Reset during REFILL beat 2
        bus.i_miss = 1; bus.i_miss_line_addr = 8'h5C; bus.i_victim_dirty = 0; bus.i_ready_mm = 1;
        @(posedge clk_inv); #1;
        bus.i_miss = 0;
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 2; c++) begin
            @(negedge clk_inv);
            if (bus.o_refill_en && bus.i_ready_mm) cnt++;
            @(posedge clk_inv); #1;
        end
        check("pre_rst_beats", cnt, 2);
        nrst = 0;
        @(posedge clk_inv); #1;
        nrst = 1;
        @(negedge clk_inv);
        check("abort_probe",   bus.o_state_probe, 3'd0);
        check("abort_stall",   bus.o_stall,       1'b0);
        check("abort_refill",  bus.o_refill_en,   1'b0);
        check("abort_line_we", bus.o_line_we,     1'b0);
        check("abort_base",    bus.o_base_addr,   8'h00);
        @(posedge clk_inv); #1;
        run_miss(8'h5D, 1'b0, 8'h00, '0, 0, 0, 0, lat);
        check("restart_beats",   n_ref, 4);
        check("restart_latency", lat, 7);
        check("restart_base",    smp_base, 8'h5D);

        // Randomized transactions against the model
        for (int t = 0; t < 120; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk_inv); #1;
            end
            run_miss(LW'($urandom), 1'($urandom_range(0, 1)), LW'($urandom),
                     {$urandom, $urandom, $urandom, $urandom}, 2, $urandom_range(0, 3), 1, lat);
            check("rand_line_we", n_lwe, 1);
        end

        repeat (2) @(posedge clk_inv);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
